// File: rtl/mux_shift_receiver.sv
// Deserialiser for the four-lane mux configuration link, oversampled in clk_i.
// Optional MUX_RX_ONEHOT_CHECK_EN builds the per-lane priority encoder and one-hot check.
module mux_shift_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          latch_i,
    input  logic                          sclk_i,
    input  logic                          TX1_data_i,
    input  logic                          TX2_data_i,
    input  logic                          RX1_data_i,
    input  logic                          RX2_data_i,
    output logic [FRAME_BITS-1:0]         TX1_word_o,
    output logic [FRAME_BITS-1:0]         TX2_word_o,
    output logic [FRAME_BITS-1:0]         RX1_word_o,
    output logic [FRAME_BITS-1:0]         RX2_word_o,
    output logic [$clog2(FRAME_BITS)-1:0] TX1_idx_o,
    output logic [$clog2(FRAME_BITS)-1:0] TX2_idx_o,
    output logic [$clog2(FRAME_BITS)-1:0] RX1_idx_o,
    output logic [$clog2(FRAME_BITS)-1:0] RX2_idx_o,
    output logic [3:0]                    onehot_err_o,
    output logic                          frame_valid_o,
    output logic                          frame_err_o,
    output logic [$clog2(FRAME_BITS):0]   bit_cnt_o,
    output logic                          busy_o
);
    localparam int IW = $clog2(FRAME_BITS);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
    localparam logic [CW-1:0] SAT_CNT  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]             latch_sync_r;
    logic [SYNC_STAGES-1:0]             sclk_sync_r;
    logic [3:0][SYNC_STAGES-1:0]        data_sync_r;
    logic [3:0]                         data_in_s;
    logic [3:0]                         data_s;
    logic                               latch_d_r;
    logic                               sclk_d_r;
    logic                               latch_s;
    logic                               sclk_s;
    logic                               latch_fall_s;
    logic                               latch_rise_s;
    logic                               sclk_rise_s;
    state_t                             state_r;
    state_t                             state_nxt_s;
    logic [3:0][FRAME_BITS-1:0]         shreg_r;
    logic [3:0][FRAME_BITS-1:0]         shreg_nxt_s;
    logic [CW-1:0]                      cnt_r;
    logic [CW-1:0]                      cnt_nxt_s;
    logic [3:0][FRAME_BITS-1:0]         word_r;
    logic [CW-1:0]                      bit_cnt_r;
    logic                               frame_valid_r;
    logic                               frame_err_r;
    logic                               busy_r;

    // Lane order throughout is {RX2, RX1, TX2, TX1}.
    assign data_in_s = {RX2_data_i, RX1_data_i, TX2_data_i, TX1_data_i};

    // Synchronisers and edge-detect registers; latch idles high so it resets to 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latch_sync_r <= '1;
            sclk_sync_r  <= '0;
            data_sync_r  <= '0;
            latch_d_r    <= 1'b1;
            sclk_d_r     <= 1'b0;
        end else begin
            latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], latch_i};
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_i};
            for (int l = 0; l < 4; l++) begin
                data_sync_r[l] <= {data_sync_r[l][SYNC_STAGES-2:0], data_in_s[l]};
            end
            latch_d_r    <= latch_s;
            sclk_d_r     <= sclk_s;
        end
    end

    // Synchronised levels and single-cycle edge strobes.
    always_comb begin
        latch_s = latch_sync_r[SYNC_STAGES-1];
        sclk_s  = sclk_sync_r[SYNC_STAGES-1];
        for (int l = 0; l < 4; l++) begin
            data_s[l] = data_sync_r[l][SYNC_STAGES-1];
        end
        latch_fall_s = ~latch_s & latch_d_r;
        latch_rise_s = latch_s & ~latch_d_r;
        sclk_rise_s  = sclk_s & ~sclk_d_r;
    end

    // Next-state, shift and count logic; a final sclk edge coinciding with latch rise still shifts.
    always_comb begin
        state_nxt_s = state_r;
        shreg_nxt_s = shreg_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (latch_fall_s) begin
                    shreg_nxt_s = '0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise_s) begin
                    if (cnt_r < FULL_CNT) begin
                        for (int l = 0; l < 4; l++) begin
                            shreg_nxt_s[l] = {shreg_r[l][FRAME_BITS-2:0], data_s[l]};
                        end
                    end else begin
                        shreg_nxt_s = shreg_r;
                    end
                    if (cnt_r != SAT_CNT) begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (latch_rise_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_CHECK: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame state, shift registers and running bit count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            shreg_r <= shreg_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Frame verdict: capture good frames, flag bad ones, keep previous words on error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_r        <= '0;
            bit_cnt_r     <= '0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= (state_nxt_s == ST_SHIFT);
            if (state_r == ST_CHECK) begin
                bit_cnt_r <= cnt_r;
                if (cnt_r == FULL_CNT) begin
                    word_r        <= shreg_r;
                    frame_valid_r <= 1'b1;
                end else begin
                    frame_err_r   <= 1'b1;
                end
            end
        end
    end

    assign TX1_word_o    = word_r[0];
    assign TX2_word_o    = word_r[1];
    assign RX1_word_o    = word_r[2];
    assign RX2_word_o    = word_r[3];
    assign bit_cnt_o     = bit_cnt_r;
    assign frame_valid_o = frame_valid_r;
    assign frame_err_o   = frame_err_r;
    assign busy_o        = busy_r;

`ifdef MUX_RX_ONEHOT_CHECK_EN
    logic [3:0][IW-1:0] idx_r;
    logic [3:0]         onehot_err_r;

    function automatic logic [IW-1:0] msb_index(input logic [FRAME_BITS-1:0] w);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (w[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [FRAME_BITS-1:0] w);
        logic [CW-1:0] pop;
        pop = '0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            pop = pop + CW'(w[i]);
        end
        return (pop == CW'(1));
    endfunction

    // Index and one-hot flags follow the words, so they only change on a good frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_r        <= '0;
            onehot_err_r <= 4'b0000;
        end else if (state_r == ST_CHECK && cnt_r == FULL_CNT) begin
            for (int l = 0; l < 4; l++) begin
                idx_r[l]        <= msb_index(shreg_r[l]);
                onehot_err_r[l] <= ~is_onehot(shreg_r[l]);
            end
        end
    end

    assign TX1_idx_o    = idx_r[0];
    assign TX2_idx_o    = idx_r[1];
    assign RX1_idx_o    = idx_r[2];
    assign RX2_idx_o    = idx_r[3];
    assign onehot_err_o = onehot_err_r;
`else
    assign TX1_idx_o    = '0;
    assign TX2_idx_o    = '0;
    assign RX1_idx_o    = '0;
    assign RX2_idx_o    = '0;
    assign onehot_err_o = 4'b0000;
`endif

endmodule

// File: tb/tb_mux_shift_receiver.sv
// Directed bench for mux_shift_receiver: good/short/long/empty frames, one-hot flags,
// mid-frame reset and a few back-to-back random frames, sclk = clk/4.
module tb_mux_shift_receiver;
`ifdef MUX_RX_ONEHOT_CHECK_EN
    localparam bit OH_EN = 1'b1;
`else
    localparam bit OH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, latch, sclk;
    logic        tx1_d, tx2_d, rx1_d, rx2_d;
    logic [31:0] tx1_w, tx2_w, rx1_w, rx2_w;
    logic [4:0]  tx1_idx, tx2_idx, rx1_idx, rx2_idx;
    logic [3:0]  onehot_err;
    logic        frame_valid, frame_err, busy;
    logic [5:0]  bit_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_both   = 0;

    mux_shift_receiver #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
        .clk_i(clk), .rst_i(rst), .latch_i(latch), .sclk_i(sclk),
        .TX1_data_i(tx1_d), .TX2_data_i(tx2_d), .RX1_data_i(rx1_d), .RX2_data_i(rx2_d),
        .TX1_word_o(tx1_w), .TX2_word_o(tx2_w), .RX1_word_o(rx1_w), .RX2_word_o(rx2_w),
        .TX1_idx_o(tx1_idx), .TX2_idx_o(tx2_idx), .RX1_idx_o(rx1_idx), .RX2_idx_o(rx2_idx),
        .onehot_err_o(onehot_err), .frame_valid_o(frame_valid), .frame_err_o(frame_err),
        .bit_cnt_o(bit_cnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (frame_valid) n_valid = n_valid + 1;
        if (frame_err)   n_ferr  = n_ferr + 1;
        if (frame_valid && frame_err) n_both = n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive nbits sclk periods (2 clk low, 2 clk high), MSB first; beyond bit 31 data is 0.
    task automatic shift_bits(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            if (i < 32) begin
                tx1_d = w0[31-i]; tx2_d = w1[31-i]; rx1_d = w2[31-i]; rx2_d = w3[31-i];
            end else begin
                tx1_d = 1'b0; tx2_d = 1'b0; rx1_d = 1'b0; rx2_d = 1'b0;
            end
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Full frame; lat reports the negedge (counted from the first edge sampling latch high)
    // at which a verdict pulse was first seen, 0 if none within the window.
    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int nbits, output int lat);
        lat = 0;
        latch = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(w0, w1, w2, w3, nbits);
        latch = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if ((frame_valid || frame_err) && lat == 0) lat = k;
        end
    endtask

    int v0, e0, lat;
    logic [31:0] r0, r1, r2, r3;

    initial begin
        rst = 1'b1; latch = 1'b1; sclk = 1'b0;
        tx1_d = 1'b0; tx2_d = 1'b0; rx1_d = 1'b0; rx2_d = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx1_word", tx1_w, 32'd0);
        check_eq("rst_bit_cnt", bit_cnt, 6'd0);
        check_eq("rst_pulses", {frame_valid, frame_err, busy}, 3'b000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Good frame
        v0 = n_valid; e0 = n_ferr;
        send_frame(32'h0000_0010, 32'h8000_0000, 32'h0000_0001, 32'h0001_0000, 32, lat);
        check_eq("good_latency", lat, 4);
        check_eq("good_valid_cnt", n_valid - v0, 1);
        check_eq("good_err_cnt", n_ferr - e0, 0);
        check_eq("good_tx1", tx1_w, 32'h0000_0010);
        check_eq("good_tx2", tx2_w, 32'h8000_0000);
        check_eq("good_rx1", rx1_w, 32'h0000_0001);
        check_eq("good_rx2", rx2_w, 32'h0001_0000);
        check_eq("good_tx1_idx", tx1_idx, OH_EN ? 5'd4 : 5'd0);
        check_eq("good_tx2_idx", tx2_idx, OH_EN ? 5'd31 : 5'd0);
        check_eq("good_rx1_idx", rx1_idx, 5'd0);
        check_eq("good_rx2_idx", rx2_idx, OH_EN ? 5'd16 : 5'd0);
        check_eq("good_onehot", onehot_err, 4'b0000);
        check_eq("good_bit_cnt", bit_cnt, 6'd32);
        check_eq("idle_busy", busy, 1'b0);

        // Short frame: 31 edges, words hold
        v0 = n_valid; e0 = n_ferr;
        send_frame(32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h0, 31, lat);
        check_eq("short_latency", lat, 4);
        check_eq("short_err_cnt", n_ferr - e0, 1);
        check_eq("short_valid_cnt", n_valid - v0, 0);
        check_eq("short_bit_cnt", bit_cnt, 6'd31);
        check_eq("short_tx1_hold", tx1_w, 32'h0000_0010);
        check_eq("short_tx2_hold", tx2_w, 32'h8000_0000);

        // Long frame: 35 edges saturate at 33
        v0 = n_valid; e0 = n_ferr;
        send_frame(32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 35, lat);
        check_eq("long_err_cnt", n_ferr - e0, 1);
        check_eq("long_valid_cnt", n_valid - v0, 0);
        check_eq("long_bit_cnt", bit_cnt, 6'd33);

        // Empty frame
        e0 = n_ferr;
        send_frame(32'h0, 32'h0, 32'h0, 32'h0, 0, lat);
        check_eq("empty_err_cnt", n_ferr - e0, 1);
        check_eq("empty_bit_cnt", bit_cnt, 6'd0);

        // Not one-hot on TX1
        v0 = n_valid;
        send_frame(32'h0000_0003, 32'h0000_0100, 32'h0000_0002, 32'h4000_0000, 32, lat);
        check_eq("oh_valid_cnt", n_valid - v0, 1);
        check_eq("oh_tx1", tx1_w, 32'h0000_0003);
        check_eq("oh_flags", onehot_err, OH_EN ? 4'b0001 : 4'b0000);
        check_eq("oh_tx1_idx", tx1_idx, OH_EN ? 5'd1 : 5'd0);
        check_eq("oh_rx2_idx", rx2_idx, OH_EN ? 5'd30 : 5'd0);

        // Reset after 16 edges
        v0 = n_valid; e0 = n_ferr;
        latch = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_0000, 32'h0000_FFFF, 16);
        check_eq("midframe_busy", busy, 1'b1);
        rst = 1'b1; latch = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("inrst_words", {tx1_w, rx2_w}, 64'd0);
        check_eq("inrst_misc", {busy, onehot_err, bit_cnt, tx1_idx}, 16'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("postrst_pulses", (n_valid - v0) + (n_ferr - e0), 0);
        check_eq("postrst_words", {tx2_w, rx1_w}, 64'd0);
        check_eq("postrst_misc", {busy, frame_valid, frame_err, bit_cnt}, 9'd0);
        send_frame(32'h0000_0800, 32'h0000_0004, 32'h0200_0000, 32'h0000_0040, 32, lat);
        check_eq("afterrst_valid_cnt", n_valid - v0, 1);
        check_eq("afterrst_err_cnt", n_ferr - e0, 0);
        check_eq("afterrst_tx1", tx1_w, 32'h0000_0800);
        check_eq("afterrst_rx2", rx2_w, 32'h0000_0040);
        check_eq("afterrst_rx1_idx", rx1_idx, OH_EN ? 5'd25 : 5'd0);

        // Back-to-back random frames
        for (int n = 0; n < 4; n++) begin
            v0 = n_valid; e0 = n_ferr;
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            send_frame(r0, r1, r2, r3, 32, lat);
            check_eq("rand_pulses", {n_valid - v0, n_ferr - e0}, {32'd1, 32'd0});
            check_eq("rand_words", {tx1_w, tx2_w}, {r0, r1});
            check_eq("rand_words_rx", {rx1_w, rx2_w}, {r2, r3});
        end

        check_eq("never_both", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
